// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU operation encoding, instruction field
// positions and the decoder used by the decode/issue stage.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // aluop 0-3 are register-register, 4-7 are shifts by an immediate amount
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;
    localparam logic [2:0] ALU_ROR = 3'd7;

    typedef struct packed {
        logic [2:0] aluop;
        logic [3:0] shamt;
        logic       src1sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       we;
        logic       is_hlt;
        logic       use_a;    // operand A read from rs
        logic       use_b;    // operand B read from rt, or rd for stores
        logic       b_is_rd;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op, input logic [3:0] lo4);
        dec_t d;
        d = '0;
        if (!op[3]) begin
            d.aluop = op[2:0];
            d.we    = 1'b1;
            d.use_a = 1'b1;
            if (op[2]) begin
                d.shamt   = lo4;
                d.src1sel = 1'b1;
            end else begin
                d.use_b = 1'b1;
            end
        end else begin
            case (op)
                OP_LW: begin
                    d.aluop   = ALU_ADD;
                    d.src1sel = 1'b1;
                    d.mem_rd  = 1'b1;
                    d.we      = 1'b1;
                    d.use_a   = 1'b1;
                end
                OP_SW: begin
                    d.aluop   = ALU_ADD;
                    d.src1sel = 1'b1;
                    d.mem_wr  = 1'b1;
                    d.use_a   = 1'b1;
                    d.use_b   = 1'b1;
                    d.b_is_rd = 1'b1;
                end
                OP_HLT:  d.is_hlt = 1'b1;
                default: d = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports with write-through from the
// single write port; R0 is hardwired to zero.
module reg_file #(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 16,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 1; i < NREG; i++) begin
                if (waddr_i == ADDR_W'(i)) regs_q[i] <= wdata_i;
            end
        end
    end

    assign raddr[0] = raddr0_i;
    assign raddr[1] = raddr1_i;

    // Addresses of R0 or beyond NREG fall through every match and read zero
    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = '0;
            if (we_i && raddr[p] == waddr_i && raddr[p] != '0) begin
                rdata[p] = wdata_i;
            end else begin
                for (int i = 1; i < NREG; i++) begin
                    if (raddr[p] == ADDR_W'(i)) rdata[p] = regs_q[i];
                end
            end
        end
    end

    assign rdata0_o = rdata[0];
    assign rdata1_o = rdata[1];

endmodule

// File: rtl/id_stage.sv
// Decode/issue stage: decodes, reads operands, stalls on RAW hazards via a
// pending-write scoreboard and holds the result in the ID/EX register.
module id_stage
    import cpu_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 16,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    output logic              id_ready,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_p0,
    output logic [DATA_W-1:0] ex_p1,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_shamt,
    output logic [2:0]        ex_aluop,
    output logic              ex_src1sel,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_we,
    output logic [ADDR_W-1:0] ex_dst,
    output logic              hlt
);

    localparam int PW = 1 << ADDR_W;

    dec_t              dec;
    logic [ADDR_W-1:0] rs_a, rt_a, rd_a, b_a;
    logic [DATA_W-1:0] rdata0, rdata1, imm;
    logic              stall, fire, dst_ok;

    logic [PW-1:0]     pending_q, pending_d;
    logic              ex_valid_q, ex_valid_d;
    logic              hlt_q, hlt_d;
    logic [DATA_W-1:0] ex_p0_q, ex_p1_q, ex_imm_q;
    logic [3:0]        ex_shamt_q;
    logic [2:0]        ex_aluop_q;
    logic              ex_src1sel_q, ex_mem_rd_q, ex_mem_wr_q, ex_we_q;
    logic [ADDR_W-1:0] ex_dst_q;

    assign dec  = decode(if_instr[OP_LSB +: FIELD_W], if_instr[RT_LSB +: FIELD_W]);
    assign rs_a = if_instr[RS_LSB +: ADDR_W];
    assign rt_a = if_instr[RT_LSB +: ADDR_W];
    assign rd_a = if_instr[RD_LSB +: ADDR_W];
    assign b_a  = dec.b_is_rd ? rd_a : rt_a;
    assign imm  = {{(DATA_W-4){if_instr[3]}}, if_instr[3:0]};

    reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr0_i (rs_a),
        .raddr1_i (b_a),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    // A source waiting on a producer is released in the producer's writeback
    // cycle, when the operand arrives through the write-through path.
    always_comb begin
        stall = 1'b0;
        if (dec.use_a && pending_q[rs_a] && !(wb_we && wb_addr == rs_a)) stall = 1'b1;
        if (dec.use_b && pending_q[b_a]  && !(wb_we && wb_addr == b_a))  stall = 1'b1;
    end

    // Handshake: upstream transfers when if_valid && id_ready; id_ready never
    // depends on if_valid. The ID/EX entry is consumed when ex_valid && ex_ready
    // and holds its outputs stable while ex_valid && !ex_ready.
    assign id_ready = !hlt_q && !stall && !flush && (!ex_valid_q || ex_ready);
    assign fire     = if_valid && id_ready;
    assign dst_ok   = (rd_a != '0) && (int'(rd_a) < NREG);

    always_comb begin
        pending_d = pending_q;
        if (wb_we) pending_d[wb_addr] = 1'b0;
        if (fire && dec.we && dst_ok) pending_d[rd_a] = 1'b1;
        // a killed producer will never write back, so release its destination
        if (flush && ex_valid_q && ex_we_q) pending_d[ex_dst_q] = 1'b0;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush)         ex_valid_d = 1'b0;
        else if (fire)     ex_valid_d = 1'b1;
        else if (ex_ready) ex_valid_d = 1'b0;
    end

    assign hlt_d = hlt_q || (fire && dec.is_hlt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            ex_valid_q   <= 1'b0;
            hlt_q        <= 1'b0;
            ex_p0_q      <= '0;
            ex_p1_q      <= '0;
            ex_imm_q     <= '0;
            ex_shamt_q   <= '0;
            ex_aluop_q   <= '0;
            ex_src1sel_q <= 1'b0;
            ex_mem_rd_q  <= 1'b0;
            ex_mem_wr_q  <= 1'b0;
            ex_we_q      <= 1'b0;
            ex_dst_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            hlt_q      <= hlt_d;
            if (fire) begin
                ex_p0_q      <= dec.use_a ? rdata0 : '0;
                ex_p1_q      <= dec.use_b ? rdata1 : '0;
                ex_imm_q     <= imm;
                ex_shamt_q   <= dec.shamt;
                ex_aluop_q   <= dec.aluop;
                ex_src1sel_q <= dec.src1sel;
                ex_mem_rd_q  <= dec.mem_rd;
                ex_mem_wr_q  <= dec.mem_wr;
                ex_we_q      <= dec.we;
                ex_dst_q     <= dec.we ? rd_a : '0;
            end
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_p0      = ex_p0_q;
    assign ex_p1      = ex_p1_q;
    assign ex_imm     = ex_imm_q;
    assign ex_shamt   = ex_shamt_q;
    assign ex_aluop   = ex_aluop_q;
    assign ex_src1sel = ex_src1sel_q;
    assign ex_mem_rd  = ex_mem_rd_q;
    assign ex_mem_wr  = ex_mem_wr_q;
    assign ex_we      = ex_we_q;
    assign ex_dst     = ex_dst_q;
    assign hlt        = hlt_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: default 16-bit build plus a DATA_W=32, NREG=8 build.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        id_ready;
    logic        flush;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [15:0] ex_p0, ex_p1, ex_imm;
    logic [3:0]  ex_shamt;
    logic [2:0]  ex_aluop;
    logic        ex_src1sel, ex_mem_rd, ex_mem_wr, ex_we;
    logic [3:0]  ex_dst;
    logic        hlt;

    logic        w_if_valid;
    logic [15:0] w_if_instr;
    logic        w_id_ready;
    logic        w_flush;
    logic        w_wb_we;
    logic [2:0]  w_wb_addr;
    logic [31:0] w_wb_data;
    logic        w_ex_ready;
    logic        w_ex_valid;
    logic [31:0] w_ex_p0, w_ex_p1, w_ex_imm;
    logic [3:0]  w_ex_shamt;
    logic [2:0]  w_ex_aluop;
    logic        w_ex_src1sel, w_ex_mem_rd, w_ex_mem_wr, w_ex_we;
    logic [2:0]  w_ex_dst;
    logic        w_hlt;

    int checks = 0;
    int errors = 0;

    id_stage u_dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .id_ready(id_ready), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_p0(ex_p0), .ex_p1(ex_p1), .ex_imm(ex_imm), .ex_shamt(ex_shamt),
        .ex_aluop(ex_aluop), .ex_src1sel(ex_src1sel), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_we(ex_we), .ex_dst(ex_dst), .hlt(hlt)
    );

    id_stage #(.DATA_W(32), .NREG(8)) u_dut32 (
        .clk(clk), .rst(rst), .if_valid(w_if_valid), .if_instr(w_if_instr),
        .id_ready(w_id_ready), .flush(w_flush), .wb_we(w_wb_we), .wb_addr(w_wb_addr),
        .wb_data(w_wb_data), .ex_ready(w_ex_ready), .ex_valid(w_ex_valid),
        .ex_p0(w_ex_p0), .ex_p1(w_ex_p1), .ex_imm(w_ex_imm), .ex_shamt(w_ex_shamt),
        .ex_aluop(w_ex_aluop), .ex_src1sel(w_ex_src1sel), .ex_mem_rd(w_ex_mem_rd),
        .ex_mem_wr(w_ex_mem_wr), .ex_we(w_ex_we), .ex_dst(w_ex_dst), .hlt(w_hlt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // one clock edge; returns at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [15:0] instr, input logic v);
        if_instr = instr;
        if_valid = v;
    endtask

    task automatic wb_drive(input logic we, input logic [3:0] a, input logic [15:0] d);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        rst = 1'b1;
        present(16'h0000, 1'b0);
        wb_drive(1'b0, 4'd0, 16'h0000);
        flush    = 1'b0;
        ex_ready = 1'b1;
        w_if_valid = 1'b0; w_if_instr = 16'h0000; w_flush = 1'b0;
        w_wb_we = 1'b0; w_wb_addr = 3'd0; w_wb_data = 32'h0; w_ex_ready = 1'b1;

        step();
        step();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_hlt", hlt, 0);
        check("rst_p0", ex_p0, 0);
        check("rst_dst", ex_dst, 0);
        check("rst_aluop", ex_aluop, 0);
        rst = 1'b0;
        #1 check("rst_id_ready", id_ready, 1);

        // write R3, then ADD R1,R3,R0
        wb_drive(1'b1, 4'd3, 16'h1234);
        step();
        wb_drive(1'b0, 4'd0, 16'h0000);
        present(16'h0130, 1'b1);
        #1 check("add_ready", id_ready, 1);
        step();
        present(16'h0000, 1'b0);
        check("add_valid", ex_valid, 1);
        check("add_p0", ex_p0, 16'h1234);
        check("add_p1", ex_p1, 16'h0000);
        check("add_we", ex_we, 1);
        check("add_dst", ex_dst, 1);
        check("add_src1sel", ex_src1sel, 0);
        wb_drive(1'b1, 4'd1, 16'h5555);
        step();
        wb_drive(1'b0, 4'd0, 16'h0000);
        check("idle_valid", ex_valid, 0);

        // LW R2,R3,-1 then dependent ADD R4,R2,R2
        present(16'h823F, 1'b1);
        step();
        check("lw_valid", ex_valid, 1);
        check("lw_mem_rd", ex_mem_rd, 1);
        check("lw_src1sel", ex_src1sel, 1);
        check("lw_imm", ex_imm, 16'hFFFF);
        check("lw_p0", ex_p0, 16'h1234);
        check("lw_dst", ex_dst, 2);
        check("lw_we", ex_we, 1);
        present(16'h0422, 1'b1);
        #1 check("raw_stall0", id_ready, 0);
        step();
        check("raw_stall1", id_ready, 0);
        check("raw_bubble", ex_valid, 0);
        wb_drive(1'b1, 4'd2, 16'h00AA);
        #1 check("raw_release", id_ready, 1);
        step();
        wb_drive(1'b0, 4'd0, 16'h0000);
        present(16'h0620, 1'b0);
        check("raw_valid", ex_valid, 1);
        check("raw_p0", ex_p0, 16'h00AA);
        check("raw_p1", ex_p1, 16'h00AA);
        check("raw_dst", ex_dst, 4);
        #1 check("r2_cleared", id_ready, 1);

        // backpressure for three cycles
        ex_ready = 1'b0;
        present(16'h0510, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", id_ready, 0);
            step();
            check("bp_valid", ex_valid, 1);
            check("bp_p0", ex_p0, 16'h00AA);
            check("bp_dst", ex_dst, 4);
        end
        ex_ready = 1'b1;
        #1 check("bp_release", id_ready, 1);
        step();
        check("bp_next_valid", ex_valid, 1);
        check("bp_next_dst", ex_dst, 5);
        check("bp_next_p0", ex_p0, 16'h5555);

        // flush kills the R5 entry and the instruction presented with it
        flush = 1'b1;
        present(16'h0730, 1'b1);
        #1 check("flush_ready", id_ready, 0);
        step();
        flush = 1'b0;
        present(16'h0850, 1'b0);
        check("flush_valid", ex_valid, 0);
        #1 check("flush_r5_free", id_ready, 1);
        present(16'h0970, 1'b0);
        #1 check("flush_r7_free", id_ready, 1);

        // back-to-back NOP, SW, shift
        present(16'hA123, 1'b1);
        step();
        check("nop_valid", ex_valid, 1);
        check("nop_we", ex_we, 0);
        check("nop_aluop", ex_aluop, 0);
        check("nop_src1sel", ex_src1sel, 0);
        check("nop_mem", {ex_mem_rd, ex_mem_wr}, 0);
        check("nop_dst", ex_dst, 0);
        present(16'h9310, 1'b1);
        step();
        check("sw_valid", ex_valid, 1);
        check("sw_p0", ex_p0, 16'h5555);
        check("sw_p1", ex_p1, 16'h1234);
        check("sw_mem_wr", ex_mem_wr, 1);
        check("sw_we", ex_we, 0);
        check("sw_src1sel", ex_src1sel, 1);
        present(16'h4612, 1'b1);
        step();
        check("sh_valid", ex_valid, 1);
        check("sh_aluop", ex_aluop, 4);
        check("sh_shamt", ex_shamt, 2);
        check("sh_src1sel", ex_src1sel, 1);
        check("sh_p0", ex_p0, 16'h5555);
        check("sh_dst", ex_dst, 6);
        check("sh_we", ex_we, 1);

        // halt is sticky
        present(16'hF000, 1'b1);
        step();
        check("hlt_set", hlt, 1);
        check("hlt_valid", ex_valid, 1);
        check("hlt_we", ex_we, 0);
        present(16'h0130, 1'b1);
        for (int i = 0; i < 12; i++) begin
            #1 check("hlt_blocks", id_ready, 0);
            step();
        end
        check("hlt_no_issue", ex_valid, 0);
        check("hlt_sticky", hlt, 1);

        // asynchronous reset mid-stream
        present(16'h0000, 1'b0);
        rst = 1'b1;
        #1 check("async_rst_hlt", hlt, 0);
        step();
        rst = 1'b0;
        present(16'h0130, 1'b1);
        #1 check("post_rst_ready", id_ready, 1);
        step();
        check("post_rst_r3", ex_p0, 16'h0000);

        // R0 ignores writes, including the write-through path
        wb_drive(1'b1, 4'd0, 16'hFFFF);
        present(16'h0100, 1'b1);
        step();
        wb_drive(1'b0, 4'd0, 16'h0000);
        check("r0_wt_p0", ex_p0, 16'h0000);
        check("r0_wt_p1", ex_p1, 16'h0000);
        step();
        present(16'h0000, 1'b0);
        check("r0_p0", ex_p0, 16'h0000);

        // 32-bit, 8-register build: register field 0xF selects R7
        w_wb_we = 1'b1; w_wb_addr = 3'd7; w_wb_data = 32'hDEADBEEF;
        step();
        w_wb_we = 1'b0;
        w_if_instr = 16'h0FF0;
        w_if_valid = 1'b1;
        #1 check("w32_ready", w_id_ready, 1);
        step();
        w_if_valid = 1'b0;
        check("w32_valid", w_ex_valid, 1);
        check("w32_p0", w_ex_p0, 32'hDEADBEEF);
        check("w32_dst", w_ex_dst, 7);
        check("w32_imm", w_ex_imm, 32'h00000000);
        w_if_instr = 16'h01F0;
        #1 check("w32_r7_pending", w_id_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
